// File: rtl/aes_block_packer_pkg.sv
// ============================================================================
// aes_block_packer_pkg : shared types and byte-slot mapping for the packer
// Revision: 1.0
// ============================================================================
`default_nettype none

package aes_block_packer_pkg;

  localparam int AES_BLOCK_BYTES = 16;

  typedef enum logic [2:0] {
    COLLECT = 3'd0,
    PAD     = 3'd1,
    ISSUE   = 3'd2,
    WAIT    = 3'd3,
    OUTPUT  = 3'd4
  } packer_state_t;

  // Stream byte idx lands at row idx%4, column idx/4; returns the MSB of that byte.
  function automatic logic [6:0] aes_byte_slot(input logic [3:0] idx);
    aes_byte_slot = 7'(127 - 8 * (4 * int'(idx[1:0]) + int'(idx[3:2])));
  endfunction

endpackage

`default_nettype wire

// File: rtl/aes_block_packer.sv
// ============================================================================
// aes_block_packer : byte stream -> 128-bit AES engine block feeder
// Optional PKCS#7 padding with AES_PKCS7_PAD_EN. Revision: 1.0
// ============================================================================
`default_nettype none

module aes_block_packer
  import aes_block_packer_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic         clk_in,
  input  logic         rst_n_in,
  input  logic [7:0]   byte_in,
  input  logic         byte_valid_in,
  input  logic         byte_last_in,
  output logic         byte_ready_out,
  output logic [127:0] eng_data_out,
  output logic         eng_init_out,
  input  logic         eng_valid_in,
  input  logic [127:0] eng_data_in,
  output logic [127:0] res_out,
  output logic         res_valid_out,
  output logic         res_last_out,
  input  logic         res_ready_in,
  output logic         error_out
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES);

`ifdef AES_PKCS7_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif

  packer_state_t      state_q;
  logic [3:0]         cnt_q;
  logic [127:0]       data_q;
  logic [127:0]       res_q;
  logic [TMO_W-1:0]   tmo_q;
  logic               ready_q;
  logic               init_q;
  logic               res_valid_q;
  logic               res_last_q;
  logic               error_q;
  logic               valid_q;
  logic               last_q;
  logic               extra_q;
  logic [7:0]         pad_byte_d;

  assign pad_byte_d = PAD_EN ? 8'(AES_BLOCK_BYTES - int'(cnt_q)) : 8'h00;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q     <= COLLECT;
      cnt_q       <= 4'd0;
      data_q      <= '0;
      res_q       <= '0;
      tmo_q       <= '0;
      ready_q     <= 1'b0;
      init_q      <= 1'b0;
      res_valid_q <= 1'b0;
      res_last_q  <= 1'b0;
      error_q     <= 1'b0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      extra_q     <= 1'b0;
    end else begin
      valid_q <= eng_valid_in;
      init_q  <= 1'b0;
      case (state_q)
        COLLECT: begin
          ready_q <= 1'b1;
          if (byte_valid_in && ready_q) begin
            data_q[aes_byte_slot(cnt_q) -: 8] <= byte_in;
            cnt_q <= cnt_q + 4'd1;
            if (cnt_q == 4'd15) begin
              // A full final block closes the message unless PKCS#7 needs a trailer block.
              ready_q <= 1'b0;
              init_q  <= 1'b1;
              last_q  <= byte_last_in && !PAD_EN;
              extra_q <= byte_last_in && PAD_EN;
              state_q <= ISSUE;
            end else if (byte_last_in) begin
              ready_q <= 1'b0;
              last_q  <= 1'b1;
              state_q <= PAD;
            end
          end
        end
        PAD: begin
          for (int i = 0; i < AES_BLOCK_BYTES; i++) begin
            if (4'(i) >= cnt_q) data_q[aes_byte_slot(4'(i)) -: 8] <= pad_byte_d;
          end
          cnt_q   <= 4'd0;
          init_q  <= 1'b1;
          state_q <= ISSUE;
        end
        ISSUE: begin
          tmo_q   <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          if (eng_valid_in && !valid_q) begin
            res_q       <= eng_data_in;
            res_valid_q <= 1'b1;
            res_last_q  <= last_q;
            state_q     <= OUTPUT;
          end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            error_q <= 1'b1;
            ready_q <= 1'b1;
            cnt_q   <= 4'd0;
            last_q  <= 1'b0;
            extra_q <= 1'b0;
            state_q <= COLLECT;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        OUTPUT: begin
          if (res_ready_in) begin
            res_valid_q <= 1'b0;
            res_last_q  <= 1'b0;
            if (extra_q) begin
              data_q  <= {AES_BLOCK_BYTES{8'h10}};
              extra_q <= 1'b0;
              last_q  <= 1'b1;
              init_q  <= 1'b1;
              state_q <= ISSUE;
            end else begin
              last_q  <= 1'b0;
              ready_q <= 1'b1;
              state_q <= COLLECT;
            end
          end
        end
        default: state_q <= COLLECT;
      endcase
    end
  end

  assign byte_ready_out = ready_q;
  assign eng_data_out   = data_q;
  assign eng_init_out   = init_q;
  assign res_out        = res_q;
  assign res_valid_out  = res_valid_q;
  assign res_last_out   = res_last_q;
  assign error_out      = error_q;

endmodule

`default_nettype wire

// File: tb/tb_aes_block_packer.sv
// ============================================================================
// tb_aes_block_packer : table-driven + scoreboard bench with a stub AES engine
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_aes_block_packer;

  localparam logic [127:0] KEY = 128'h0004080c0105090d02060a0e03070b0f;
  localparam logic [127:0] C1  = 128'h004488cc115599dd2266aaee3377bbff;
`ifdef AES_PKCS7_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  logic         clk_in = 1'b0;
  logic         rst_n_in;
  logic [7:0]   byte_in;
  logic         byte_valid_in;
  logic         byte_last_in;
  logic         byte_ready_out;
  logic [127:0] eng_data_out;
  logic         eng_init_out;
  logic         eng_valid_in;
  logic [127:0] eng_data_in;
  logic [127:0] res_out;
  logic         res_valid_out;
  logic         res_last_out;
  logic         res_ready_in;
  logic         error_out;

  always #5 clk_in = ~clk_in;

  aes_block_packer #(.TIMEOUT_CYCLES(64)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .byte_in(byte_in), .byte_valid_in(byte_valid_in), .byte_last_in(byte_last_in),
    .byte_ready_out(byte_ready_out),
    .eng_data_out(eng_data_out), .eng_init_out(eng_init_out),
    .eng_valid_in(eng_valid_in), .eng_data_in(eng_data_in),
    .res_out(res_out), .res_valid_out(res_valid_out), .res_last_out(res_last_out),
    .res_ready_in(res_ready_in), .error_out(error_out)
  );

  typedef struct { logic [127:0] d; bit last; } exp_t;
  typedef struct {
    int n; logic [7:0] base; logic [7:0] step; bit fin;
    bit has_exp; logic [127:0] exp_first; int blocks;
  } vec_t;

  exp_t q_blk[$];
  exp_t q_res[$];
  exp_t mon_e;
  int   n_vec = 0, n_miss = 0, n_init = 0;
  bit   hang = 1'b0, prev_init = 1'b0, have_obs = 1'b0;
  int   lat = 5;
  logic [127:0] obs_eng;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    n_vec++;
    n_miss++;
    $display("FAIL %s: got timeout expected completion", nm);
  endtask

  function automatic logic [127:0] eng_f(input logic [127:0] x);
    return {x[63:0], x[127:64]} ^ KEY;
  endfunction

  // Stub engine: valid drops on init, rises lat cycles later unless hung.
  int e_cnt;
  bit e_busy;
  logic [127:0] e_blk;
  always @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      e_busy       <= 1'b0;
      e_cnt        <= 0;
      e_blk        <= '0;
      eng_valid_in <= 1'b0;
      eng_data_in  <= '0;
    end else if (eng_init_out) begin
      eng_valid_in <= 1'b0;
      e_busy       <= 1'b1;
      e_cnt        <= lat;
      e_blk        <= eng_data_out;
    end else if (e_busy) begin
      if (e_cnt <= 1) begin
        e_busy <= hang;
        if (!hang) begin
          eng_valid_in <= 1'b1;
          eng_data_in  <= eng_f(e_blk);
        end
      end else begin
        e_cnt <= e_cnt - 1;
      end
    end
  end

  always @(negedge clk_in) begin
    if (rst_n_in) begin
      if (eng_init_out) begin
        n_init++;
        chk("init_width", 128'(prev_init), 128'd0);
        if (!have_obs) begin
          obs_eng  = eng_data_out;
          have_obs = 1'b1;
        end
        if (q_blk.size() == 0) begin
          n_vec++; n_miss++;
          $display("FAIL init_unexpected: got block %h expected none", eng_data_out);
        end else begin
          mon_e = q_blk.pop_front();
          chk("eng_data", eng_data_out, mon_e.d);
          if (!hang) q_res.push_back('{d: eng_f(mon_e.d), last: mon_e.last});
        end
      end
      if (res_valid_out && res_ready_in) begin
        if (q_res.size() == 0) begin
          n_vec++; n_miss++;
          $display("FAIL res_unexpected: got %h expected no result", res_out);
        end else begin
          mon_e = q_res.pop_front();
          chk("res_out", res_out, mon_e.d);
          chk("res_last", 128'(res_last_out), 128'(mon_e.last));
        end
      end
    end
    prev_init = eng_init_out;
  end

  task automatic push_msg(input int n, input logic [7:0] base, input logic [7:0] step, input bit fin);
    logic [127:0] blk;
    exp_t e;
    int k;
    blk = '0;
    k = 0;
    for (int i = 0; i < n; i++) begin
      blk[127 - 8 * (4 * (k % 4) + k / 4) -: 8] = base + 8'(i) * step;
      k++;
      if (k == 16) begin
        e.d = blk; e.last = fin && (i == n - 1) && !PAD;
        q_blk.push_back(e);
        blk = '0; k = 0;
      end
    end
    if (k != 0) begin
      for (int j = k; j < 16; j++) blk[127 - 8 * (4 * (j % 4) + j / 4) -: 8] = PAD ? 8'(16 - k) : 8'h00;
      e.d = blk; e.last = fin;
      q_blk.push_back(e);
    end else if (fin && PAD) begin
      e.d = {16{8'h10}}; e.last = 1'b1;
      q_blk.push_back(e);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit l);
    int t;
    byte_in = b; byte_valid_in = 1'b1; byte_last_in = l;
    t = 0;
    while (!byte_ready_out && t < 2000) begin
      @(negedge clk_in);
      t++;
    end
    if (t >= 2000) fail_now("byte_ready_wait");
    @(negedge clk_in);
    byte_valid_in = 1'b0; byte_last_in = 1'b0;
  endtask

  task automatic send_msg(input int n, input logic [7:0] base, input logic [7:0] step, input bit fin);
    push_msg(n, base, step, fin);
    for (int i = 0; i < n; i++) send_byte(base + 8'(i) * step, fin && (i == n - 1));
  endtask

  task automatic drain();
    int t = 0;
    while ((q_blk.size() != 0 || q_res.size() != 0 || !byte_ready_out) && t < 3000) begin
      @(negedge clk_in);
      t++;
    end
    if (t >= 3000) fail_now("drain");
  endtask

  task automatic wait_init(input int n0);
    int t = 0;
    #1;
    while (n_init == n0 && t < 2000) begin
      @(negedge clk_in);
      #1;
      t++;
    end
    if (t >= 2000) fail_now("init_wait");
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, 128'(byte_ready_out), 128'd0);
    chk({tag, "_eng"},   eng_data_out, 128'd0);
    chk({tag, "_init"},  128'(eng_init_out), 128'd0);
    chk({tag, "_res"},   res_out, 128'd0);
    chk({tag, "_valid"}, 128'(res_valid_out), 128'd0);
    chk({tag, "_last"},  128'(res_last_out), 128'd0);
    chk({tag, "_err"},   128'(error_out), 128'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  vec_t vt[7];
  int   n0;

  initial begin
    vt[0] = '{16, 8'h00, 8'h11, 1'b1, 1'b1, C1, PAD ? 2 : 1};
    vt[1] = '{3, 8'haa, 8'h11, 1'b1, 1'b1,
              PAD ? 128'haa0d0d0dbb0d0d0dcc0d0d0d0d0d0d0d : 128'haa000000bb000000cc00000000000000, 1};
    vt[2] = '{1, 8'h5a, 8'h01, 1'b1, 1'b0, 128'd0, 1};
    vt[3] = '{15, 8'h01, 8'h01, 1'b1, 1'b0, 128'd0, 1};
    vt[4] = '{20, 8'h30, 8'h01, 1'b1, 1'b0, 128'd0, 2};
    vt[5] = '{32, 8'h07, 8'h05, 1'b1, 1'b0, 128'd0, PAD ? 3 : 2};
    vt[6] = '{16, 8'hc0, 8'h01, 1'b0, 1'b0, 128'd0, 1};

    rst_n_in = 1'b0; byte_in = 8'h00; byte_valid_in = 1'b0; byte_last_in = 1'b0;
    res_ready_in = 1'b1;
    #1;
    chk_all_zero("reset");
    repeat (2) @(negedge clk_in);
    rst_n_in = 1'b1;
    @(posedge clk_in);
    #1;
    chk("ready_after_reset", 128'(byte_ready_out), 128'd1);
    @(negedge clk_in);

    foreach (vt[i]) begin
      have_obs = 1'b0;
      n0 = n_init;
      send_msg(vt[i].n, vt[i].base, vt[i].step, vt[i].fin);
      drain();
      if (vt[i].has_exp) chk("first_eng", obs_eng, vt[i].exp_first);
      chk("init_count", 128'(n_init - n0), 128'(vt[i].blocks));
    end

    // Downstream back-pressure holds the result and blocks the byte input.
    res_ready_in = 1'b0;
    send_msg(16, 8'h00, 8'h11, 1'b0);
    begin
      int t = 0;
      while (!res_valid_out && t < 2000) begin @(negedge clk_in); t++; end
      if (t >= 2000) fail_now("stall_valid_wait");
    end
    repeat (20) begin
      @(negedge clk_in);
      chk("stall_res", res_out, eng_f(C1));
      chk("stall_valid", 128'(res_valid_out), 128'd1);
      chk("stall_ready", 128'(byte_ready_out), 128'd0);
    end
    @(posedge clk_in);
    #1 res_ready_in = 1'b1;
    @(negedge clk_in);
    @(negedge clk_in);
    chk("accept_ready", 128'(byte_ready_out), 128'd1);
    chk("accept_valid", 128'(res_valid_out), 128'd0);
    drain();

    // Hung engine: error exactly TIMEOUT_CYCLES cycles after entering WAIT.
    hang = 1'b1;
    n0 = n_init;
    send_msg(16, 8'h21, 8'h03, 1'b0);
    wait_init(n0);
    @(posedge clk_in);
    repeat (63) begin
      @(posedge clk_in);
      #1;
      chk("tmo_err_early", 128'(error_out), 128'd0);
    end
    @(posedge clk_in);
    #1;
    chk("tmo_err", 128'(error_out), 128'd1);
    chk("tmo_ready", 128'(byte_ready_out), 128'd1);
    chk("tmo_no_valid", 128'(res_valid_out), 128'd0);
    hang = 1'b0;
    @(negedge clk_in);
    send_msg(3, 8'haa, 8'h11, 1'b1);
    drain();
    chk("err_sticky", 128'(error_out), 128'd1);

    // Reset during WAIT discards the block; a fresh block afterwards is clean.
    lat = 30;
    n0 = n_init;
    send_msg(16, 8'h00, 8'h11, 1'b0);
    wait_init(n0);
    repeat (4) @(posedge clk_in);
    #2 rst_n_in = 1'b0;
    #1;
    chk_all_zero("mid_rst");
    q_blk.delete();
    q_res.delete();
    repeat (3) @(negedge clk_in);
    rst_n_in = 1'b1;
    n0 = n_init;
    repeat (10) @(negedge clk_in);
    #1;
    chk("post_rst_no_init", 128'(n_init - n0), 128'd0);
    chk("post_rst_ready", 128'(byte_ready_out), 128'd1);
    chk("post_rst_valid", 128'(res_valid_out), 128'd0);
    lat = 5;
    have_obs = 1'b0;
    @(negedge clk_in);
    send_msg(16, 8'h00, 8'h11, 1'b1);
    drain();
    chk("post_rst_eng", obs_eng, C1);
    chk("post_rst_err", 128'(error_out), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire
